// File: rtl/fence_sequencer_pkg.sv
// fence_sequencer_pkg: shared types for the fence-class commit sequencer.
//   fence_op_t        - fence-class operation encoding as presented at commit port 0
//   fence_seq_state_e - sequencer FSM states
package fence_sequencer_pkg;

    typedef enum logic [1:0] {
        FENCE_OP_FENCE      = 2'd0,
        FENCE_OP_FENCE_I    = 2'd1,
        FENCE_OP_SFENCE_VMA = 2'd2
    } fence_op_t;

    // Encoding 3 is reserved and is never accepted.
    localparam logic [1:0] FENCE_OP_RESERVED = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        D_FLUSH,
        I_FLUSH,
        TLB,
        DONE
    } fence_seq_state_e;

endpackage

// File: rtl/fence_sequencer.sv
// fence_sequencer: multi-cycle controller for FENCE / FENCE.I / SFENCE.VMA at the
// head of commit port 0. It drains the store buffer, flushes D$, then flushes I$ or
// the TLBs, and finally pulses done/flush_pipeline back to commit.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i, req_op_i   fence-class request at commit port 0 (sampled in IDLE only)
//   halt_i                  blocks acceptance of new requests
//   no_st_pending_i         store buffer empty
//   dcache_flush_o/_ack_i   D$ flush request (level) and completion pulse
//   icache_flush_o          I$ invalidate pulse
//   tlb_flush_o             TLB flush pulse
//   done_o                  commit acks port 0 this cycle
//   flush_pipeline_o        pipeline flush pulse, coincident with done_o
//   busy_o                  sequencer is not IDLE
//   timeout_o               D$ ack timeout pulse
//
// Build option: define FENCE_SEQ_TIMEOUT_EN to bound the D$ ack wait to
// TIMEOUT_CYCLES; otherwise the wait is unbounded and timeout_o is tied 0.
//
// All outputs are decodes of registered state only.
module fence_sequencer
    import fence_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_op_i,
    input  logic       halt_i,
    input  logic       no_st_pending_i,
    output logic       dcache_flush_o,
    input  logic       dcache_flush_ack_i,
    output logic       icache_flush_o,
    output logic       tlb_flush_o,
    output logic       done_o,
    output logic       flush_pipeline_o,
    output logic       busy_o,
    output logic       timeout_o
);

    fence_seq_state_e state_q, state_d;
    fence_op_t        op_q, op_d;

`ifdef FENCE_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_hit;

    // Count reaches the limit after TIMEOUT_CYCLES ack-less D_FLUSH cycles; the
    // following cycle is the timeout cycle (flush request dropped, timeout pulsed).
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= FENCE_OP_FENCE;
`ifdef FENCE_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
`ifdef FENCE_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
`ifdef FENCE_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i && !halt_i && (req_op_i != FENCE_OP_RESERVED)) begin
                    op_d    = fence_op_t'(req_op_i);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
`ifdef FENCE_SEQ_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (no_st_pending_i) begin
                    state_d = (op_q == FENCE_OP_SFENCE_VMA) ? TLB : D_FLUSH;
                end
            end
            D_FLUSH: begin
`ifdef FENCE_SEQ_TIMEOUT_EN
                if (tmo_hit) begin
                    state_d = DONE;
                end else if (dcache_flush_ack_i) begin
                    state_d = (op_q == FENCE_OP_FENCE_I) ? I_FLUSH : DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (dcache_flush_ack_i) begin
                    state_d = (op_q == FENCE_OP_FENCE_I) ? I_FLUSH : DONE;
                end
`endif
            end
            I_FLUSH: state_d = DONE;
            TLB:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef FENCE_SEQ_TIMEOUT_EN
    assign dcache_flush_o = (state_q == D_FLUSH) && !tmo_hit;
    assign timeout_o      = (state_q == D_FLUSH) && tmo_hit;
`else
    assign dcache_flush_o = (state_q == D_FLUSH);
    assign timeout_o      = 1'b0;
`endif
    assign icache_flush_o   = (state_q == I_FLUSH);
    assign tlb_flush_o      = (state_q == TLB);
    assign done_o           = (state_q == DONE);
    assign flush_pipeline_o = (state_q == DONE);
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_fence_sequencer.sv
// tb_fence_sequencer: directed, table-driven bench for fence_sequencer plus
// hand-written sequences for reset abort and (when FENCE_SEQ_TIMEOUT_EN is defined)
// the D$ ack timeout. Each vector is driven on the falling edge; outputs are
// compared 1 time unit after the following rising edge.
module tb_fence_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_op;
    logic       halt;
    logic       no_st;
    logic       dack;
    logic       dfl, ifl, tlbf, done, fpipe, busy, tmo;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        string      nm;
        logic       rst;
        logic       v;
        logic [1:0] op;
        logic       h;
        logic       ns;
        logic       ack;
        logic       e_dfl;
        logic       e_ifl;
        logic       e_tlb;
        logic       e_done;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fence_sequencer #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .req_op_i           (req_op),
        .halt_i             (halt),
        .no_st_pending_i    (no_st),
        .dcache_flush_o     (dfl),
        .dcache_flush_ack_i (dack),
        .icache_flush_o     (ifl),
        .tlb_flush_o        (tlbf),
        .done_o             (done),
        .flush_pipeline_o   (fpipe),
        .busy_o             (busy),
        .timeout_o          (tmo)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string nm, input logic e_dfl, input logic e_ifl,
                              input logic e_tlb, input logic e_done, input logic e_busy,
                              input logic e_tmo);
        chk({nm, ".dcache_flush"}, dfl, e_dfl);
        chk({nm, ".icache_flush"}, ifl, e_ifl);
        chk({nm, ".tlb_flush"}, tlbf, e_tlb);
        chk({nm, ".done"}, done, e_done);
        chk({nm, ".flush_pipeline"}, fpipe, e_done);
        chk({nm, ".busy"}, busy, e_busy);
        chk({nm, ".timeout"}, tmo, e_tmo);
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] op,
                         input logic h, input logic ns, input logic ack);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_op    = op;
        halt      = h;
        no_st     = ns;
        dack      = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input logic r, input logic v, input logic [1:0] op,
                       input logic h, input logic ns, input logic ack,
                       input logic e_dfl, input logic e_ifl, input logic e_tlb,
                       input logic e_done, input logic e_busy);
        vec_t t;
        t.nm = nm; t.rst = r; t.v = v; t.op = op; t.h = h; t.ns = ns; t.ack = ack;
        t.e_dfl = e_dfl; t.e_ifl = e_ifl; t.e_tlb = e_tlb; t.e_done = e_done; t.e_busy = e_busy;
        vecs.push_back(t);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; halt = 1'b0; no_st = 1'b0; dack = 1'b0;

        //   name            rst v op h ns ack   dfl ifl tlb done busy
        add("reset",          1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add("post_reset",     0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add("ack_in_idle",    0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0);
        // FENCE with immediate ack
        add("fence_acc",      0, 1, 0, 0, 1, 0,   0, 0, 0, 0, 1);
        add("fence_dflush",   0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1);
        add("fence_done",     0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1);
        add("fence_no_b2b",   0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        // FENCE_I: store buffer busy 5 DRAIN cycles, halt raised mid-sequence
        add("fi_acc",         0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            add("fi_drain",   0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 1);
        add("fi_dflush1",     0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            add("fi_dflush_w",0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1);
        add("fi_iflush",      0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 1);
        add("fi_done",        0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1);
        add("fi_idle",        0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
        // SFENCE_VMA with a stray D$ ack during DRAIN and in TLB
        add("sf_acc",         0, 1, 2, 0, 1, 0,   0, 0, 0, 0, 1);
        add("sf_tlb",         0, 1, 3, 0, 1, 1,   0, 0, 1, 0, 1);
        add("sf_done",        0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1);
        add("sf_idle",        0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
        // Reserved op is ignored
        add("rsvd_op",        0, 1, 3, 0, 1, 0,   0, 0, 0, 0, 0);
        add("rsvd_op2",       0, 1, 3, 0, 1, 0,   0, 0, 0, 0, 0);
        // Halt blocks acceptance; accepted on the edge after it drops
        for (int i = 0; i < 10; i++)
            add("halt_hold",  0, 1, 0, 1, 1, 0,   0, 0, 0, 0, 0);
        add("halt_drop_acc",  0, 1, 0, 0, 1, 0,   0, 0, 0, 0, 1);
        add("halt_dflush",    0, 1, 0, 1, 1, 0,   1, 0, 0, 0, 1);
        add("halt_done",      0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1);
        add("halt_idle",      0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].h, vecs[i].ns, vecs[i].ack);
            step();
            check_outs(vecs[i].nm, vecs[i].e_dfl, vecs[i].e_ifl, vecs[i].e_tlb,
                       vecs[i].e_done, vecs[i].e_busy, 1'b0);
        end

        // Reset in D_FLUSH aborts immediately with no done afterwards
        drive(0, 1, 0, 0, 1, 0); step();
        check_outs("abort_drain", 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0); step();
        check_outs("abort_dflush", 1, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0); #1;
        check_outs("abort_async", 0, 0, 0, 0, 0, 0);
        step();
        check_outs("abort_held", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 1); step();
            check_outs("abort_after", 0, 0, 0, 0, 0, 0);
        end

`ifdef FENCE_SEQ_TIMEOUT_EN
        // No ack: 8 D_FLUSH cycles, then timeout cycle, then DONE
        drive(0, 1, 0, 0, 1, 0); step();
        check_outs("to_drain", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1, 0); step();
            check_outs("to_dflush", 1, 0, 0, 0, 1, 0);
        end
        drive(0, 0, 0, 0, 1, 0); step();
        check_outs("to_pulse", 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 0); step();
        check_outs("to_done", 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0); step();
        check_outs("to_idle", 0, 0, 0, 0, 0, 0);
        // Ack in the 8th D_FLUSH cycle beats the timeout
        drive(0, 1, 0, 0, 1, 0); step();
        check_outs("tack_drain", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1, 0); step();
            check_outs("tack_dflush", 1, 0, 0, 0, 1, 0);
        end
        drive(0, 0, 0, 0, 1, 1); step();
        check_outs("tack_done", 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0); step();
        check_outs("tack_idle", 0, 0, 0, 0, 0, 0);
`else
        // Without the timeout option the ack wait is unbounded
        drive(0, 1, 0, 0, 1, 0); step();
        check_outs("long_drain", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 1, 0); step();
            check_outs("long_dflush", 1, 0, 0, 0, 1, 0);
        end
        drive(0, 0, 0, 0, 1, 1); step();
        check_outs("long_done", 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0); step();
        check_outs("long_idle", 0, 0, 0, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fence_sequencer.md
Name: fence_sequencer

Overview:
- Multi-cycle controller for the fence-class instructions FENCE, FENCE.I and SFENCE.VMA, which sit at the head of commit port 0.
- Steps through the sequence: drain the store buffer, flush D$, flush I$ or TLBs, flush the pipeline.
- Raises a single-cycle done back to the commit logic, which then acks the instruction.
- Sits between commit and the cache and MMU flush interfaces, replacing ad-hoc per-instruction combinational stalls.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles spent in D_FLUSH waiting for ack (used only with the optional feature).
- CNT_W, 11: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  1  a fence-class instruction is valid at commit port 0 with no exception
- req_op_i  in  2  0=FENCE, 1=FENCE_I, 2=SFENCE_VMA, 3=reserved
- halt_i  in  1  halt request from the controller
- no_st_pending_i  in  1  store buffer empty
- dcache_flush_o  out  1  D$ flush request, level, held until ack
- dcache_flush_ack_i  in  1  D$ flush complete, single-cycle pulse
- icache_flush_o  out  1  I$ invalidate, single-cycle pulse
- tlb_flush_o  out  1  TLB flush, single-cycle pulse
- done_o  out  1  single-cycle pulse; commit acks port 0 this cycle
- flush_pipeline_o  out  1  single-cycle pulse, coincident with done_o
- busy_o  out  1  high in every state except IDLE
- timeout_o  out  1  single-cycle pulse on D$ ack timeout (optional feature only; otherwise tied 0)

Behaviour:
- Reset: state=IDLE, latched op=0, counter=0. All outputs are 0 during reset and in the first cycle after reset.
- Reset mid-sequence: aborts immediately; no done_o pulse.
- All outputs are registered state decodes; there is no combinational path from any input to any output.

State machine (one transition per cycle):
- IDLE:
  - If req_valid_i && !halt_i && req_op_i!=3, latch req_op_i and go to DRAIN.
  - req_op_i==3 is ignored and the block stays in IDLE.
  - Under halt_i, the block stays in IDLE.
- DRAIN:
  - Waits while !no_st_pending_i.
  - Once no_st_pending_i: FENCE or FENCE_I go to D_FLUSH; SFENCE_VMA goes to TLB.
- D_FLUSH:
  - dcache_flush_o=1 in every D_FLUSH cycle, including the first.
  - dcache_flush_ack_i is sampled only in D_FLUSH. On ack: FENCE goes to DONE; FENCE_I goes to I_FLUSH.
  - An ack arriving in any other state is ignored.
- I_FLUSH: icache_flush_o=1 for exactly one cycle, then DONE.
- TLB: tlb_flush_o=1 for exactly one cycle, then DONE.
- DONE: done_o=1 and flush_pipeline_o=1 for one cycle, then IDLE. A new request is accepted no earlier than the cycle after DONE.

Rules:
- req_valid_i and req_op_i are sampled only in IDLE. Deassertion mid-sequence does not abort; the operations are idempotent.
- halt_i affects acceptance only; a sequence already started runs to completion.
- Minimum latency, counted from the acceptance edge to done_o:
  - SFENCE_VMA: 3 cycles (DRAIN, TLB, DONE).
  - FENCE with immediate ack: 3 cycles.
  - FENCE_I with immediate ack: 4 cycles.
- Without the optional feature, the wait for dcache_flush_ack_i is unbounded.

Optional Feature:
- Macro: FENCE_SEQ_TIMEOUT_EN.
- Defined:
  - A CNT_W counter clears on entry to D_FLUSH and increments every D_FLUSH cycle without ack.
  - When it reaches TIMEOUT_CYCLES: dcache_flush_o drops, timeout_o pulses for one cycle, and the state goes to DONE. done_o then pulses in the following cycle.
  - An ack in the same cycle the count is reached wins; timeout_o is not asserted.
- Undefined: no counter; timeout_o is tied to 0.

Decomposition:
- ariane_pkg additions:
  - fence_op_t enum (FENCE_OP_FENCE, FENCE_OP_FENCE_I, FENCE_OP_SFENCE_VMA).
  - fence_seq_state_e enum (IDLE, DRAIN, D_FLUSH, I_FLUSH, TLB, DONE).
- Single module with no sub-module. The timeout counter is small enough to stay inline under the macro.

Test Plan:
- FENCE, no_st_pending_i=1, ack in the 1st D_FLUSH cycle -> dcache_flush_o high 1 cycle; done_o and flush_pipeline_o 3 cycles after acceptance; icache_flush_o and tlb_flush_o stay 0.
- FENCE_I, no_st_pending_i low for 5 cycles, ack after 4 D_FLUSH cycles -> DRAIN 6 cycles, dcache_flush_o high 4 cycles, then icache_flush_o 1 cycle, then done_o the next cycle.
- SFENCE_VMA, stray dcache_flush_ack_i during DRAIN -> ack ignored; dcache_flush_o never asserted; tlb_flush_o 1 cycle; done_o 3 cycles after acceptance.
- req_valid_i with halt_i=1 for 10 cycles -> busy_o stays 0. Drop halt_i -> accepted the next edge.
- FENCE, rst_i asserted in D_FLUSH -> all outputs 0 immediately; after release, state is IDLE and no done_o ever occurs for the aborted request.
- FENCE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> dcache_flush_o high 8 cycles, timeout_o pulse, done_o next cycle. Repeat with ack on cycle 8 -> no timeout_o.
